laplace_cross_window: RTL and testbench

- Streaming window generator that sits directly upstream of the approximate Laplacian stage.
- Accepts a raster-order 8-bit pixel stream, one pixel per accepted cycle.
- Emits the 5-pixel cross neighbourhood (b above, d left, e centre, f right, h below) for every interior pixel of the frame.
- Two line buffers plus horizontal delay registers; no border padding, so the downstream image is (IMG_W-2) x (IMG_H-2).

---
 rtl/laplace_cross_window_pkg.sv | 23 ++
 rtl/laplace_cross_window_line_buffer.sv | 27 ++
 rtl/laplace_cross_window.sv | 136 +++++++++++++
 tb/tb_laplace_cross_window.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laplace_cross_window_pkg.sv
// Shared definitions for the cross-window generator, the Laplacian stage
// and its output collector: pixel width, default frame size, counter widths.
package laplace_cross_window_pkg;

   localparam int PIX_W     = 8;
   localparam int IMG_W_DEF = 256;
   localparam int IMG_H_DEF = 256;

   // Counter/address width for a range of n values; never narrower than 1 bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Cross neighbourhood around centre e: b above, d left, f right, h below.
   typedef struct packed {
      logic [PIX_W-1:0] b;
      logic [PIX_W-1:0] d;
      logic [PIX_W-1:0] e;
      logic [PIX_W-1:0] f;
      logic [PIX_W-1:0] h;
   } cross_win_t;

endpackage

// File: rtl/laplace_cross_window_line_buffer.sv
// One raster line of storage. The read is combinational on the same address
// that is written, so a write cycle returns the previous line's pixel.
module line_buffer
   import laplace_cross_window_pkg::*;
#(
   parameter int DEPTH = IMG_W_DEF,
   parameter int WIDTH = PIX_W
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [cnt_w(DEPTH)-1:0]   addr,
   input  logic [WIDTH-1:0]          wdata,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   assign rdata = mem_q[addr];

   // Contents need no reset: no window reads a row not yet written this frame.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

endmodule

// File: rtl/laplace_cross_window.sv
// Streaming 5-pixel cross window generator feeding the Laplacian stage.
// Windows are produced only for interior pixels, so the output image is
// (IMG_W-2) x (IMG_H-2). Accepting pixel (r,c) emits the window centred
// on (r-1,c-1) one clock later.
module laplace_cross_window
   import laplace_cross_window_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pix,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_b,
   output logic [PIX_W-1:0] out_d,
   output logic [PIX_W-1:0] out_e,
   output logic [PIX_W-1:0] out_f,
   output logic [PIX_W-1:0] out_h,
   output logic             out_last,
   output logic             frame_done
);

   localparam int CW = cnt_w(IMG_W);
   localparam int RW = cnt_w(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]    col_q, col_d, cur_col;
   logic [RW-1:0]    row_q, row_d, cur_row;
   logic [PIX_W-1:0] top_q, top_d;
   logic [PIX_W-1:0] mid1_q, mid1_d;
   logic [PIX_W-1:0] mid2_q, mid2_d;
   logic [PIX_W-1:0] bot_q, bot_d;
   cross_win_t       win_q, win_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             frame_done_q, frame_done_d;
   logic [PIX_W-1:0] lb1_rdata, lb2_rdata;
   logic             win_hit, at_last;

   // A start-of-frame pixel lands at (0,0) whatever the counters say.
   assign cur_col = (in_valid && in_sof) ? '0 : col_q;
   assign cur_row = (in_valid && in_sof) ? '0 : row_q;
   assign win_hit = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
   assign at_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

   // lb1 carries row r-1 and feeds lb2, which carries row r-2.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
      .clk   (clk),
      .we    (in_valid),
      .addr  (cur_col),
      .wdata (in_pix),
      .rdata (lb1_rdata)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
      .clk   (clk),
      .we    (in_valid),
      .addr  (cur_col),
      .wdata (lb1_rdata),
      .rdata (lb2_rdata)
   );

   // Next-state: raster counters, horizontal taps and the registered window.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      top_d        = top_q;
      mid1_d       = mid1_q;
      mid2_d       = mid2_q;
      bot_d        = bot_q;
      win_d        = win_q;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      frame_done_d = 1'b0;
      if (in_valid) begin
         top_d  = lb2_rdata;
         mid1_d = lb1_rdata;
         mid2_d = mid1_q;
         bot_d  = in_pix;
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
         if (win_hit) begin
            out_valid_d = 1'b1;
            out_last_d  = at_last;
            win_d       = '{b: top_q, d: mid2_q, e: mid1_q, f: lb1_rdata, h: bot_q};
         end
         frame_done_d = at_last;
      end
   end

   // State and output registers; line-buffer contents are left unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         top_q        <= '0;
         mid1_q       <= '0;
         mid2_q       <= '0;
         bot_q        <= '0;
         win_q        <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         top_q        <= top_d;
         mid1_q       <= mid1_d;
         mid2_q       <= mid2_d;
         bot_q        <= bot_d;
         win_q        <= win_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_b      = win_q.b;
   assign out_d      = win_q.d;
   assign out_e      = win_q.e;
   assign out_f      = win_q.f;
   assign out_h      = win_q.h;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_laplace_cross_window.sv
// Bench for laplace_cross_window: a 4x4 instance for the directed scenarios
// and a 256x256 instance for a random full frame. A frame-image model pushes
// each expected window (with its due cycle) when the producing pixel is driven.
module tb_laplace_cross_window;

   typedef struct packed { logic v; logic sof; logic [7:0] pix; } stim_t;
   typedef struct { logic [41:0] win; int cyc; } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       s_in_valid = 1'b0, s_in_sof = 1'b0;
   logic [7:0] s_in_pix = 8'h00;
   logic       s_out_valid, s_out_last, s_frame_done;
   logic [7:0] s_out_b, s_out_d, s_out_e, s_out_f, s_out_h;

   logic       l_in_valid = 1'b0, l_in_sof = 1'b0;
   logic [7:0] l_in_pix = 8'h00;
   logic       l_out_valid, l_out_last, l_frame_done;
   logic [7:0] l_out_b, l_out_d, l_out_e, l_out_f, l_out_h;

   logic [41:0] got_s, got_l;
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   exp_t  q[$];
   stim_t st[$];
   int    m_row = 0;
   int    m_col = 0;
   logic [7:0] img [0:255][0:255];

   laplace_cross_window #(.IMG_W(4), .IMG_H(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_sof(s_in_sof), .in_pix(s_in_pix),
      .out_valid(s_out_valid), .out_b(s_out_b), .out_d(s_out_d), .out_e(s_out_e),
      .out_f(s_out_f), .out_h(s_out_h), .out_last(s_out_last), .frame_done(s_frame_done)
   );

   laplace_cross_window #(.IMG_W(256), .IMG_H(256)) dut_l (
      .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_sof(l_in_sof), .in_pix(l_in_pix),
      .out_valid(l_out_valid), .out_b(l_out_b), .out_d(l_out_d), .out_e(l_out_e),
      .out_f(l_out_f), .out_h(l_out_h), .out_last(l_out_last), .frame_done(l_frame_done)
   );

   assign got_s = {s_out_b, s_out_d, s_out_e, s_out_f, s_out_h, s_out_last, s_frame_done};
   assign got_l = {l_out_b, l_out_d, l_out_e, l_out_f, l_out_h, l_out_last, l_frame_done};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Drive one cycle of input and update the frame model / expected queue.
   task automatic drive(input bit big, input logic v, input logic sof, input logic [7:0] p);
      int w, h;
      logic lst;
      exp_t ex;
      w = big ? 256 : 4;
      h = big ? 256 : 4;
      if (big) begin
         l_in_valid = v; l_in_sof = sof; l_in_pix = p;
      end else begin
         s_in_valid = v; s_in_sof = sof; s_in_pix = p;
      end
      if (v) begin
         if (sof) begin
            m_row = 0; m_col = 0;
         end
         img[m_row][m_col] = p;
         if (m_row >= 2 && m_col >= 2) begin
            lst = (m_row == h - 1) && (m_col == w - 1);
            ex.win = {img[m_row-2][m_col-1], img[m_row-1][m_col-2], img[m_row-1][m_col-1],
                      img[m_row-1][m_col], img[m_row][m_col-1], lst, lst};
            ex.cyc = cyc + 1;
            q.push_back(ex);
         end
         if (m_col == w - 1) begin
            m_col = 0;
            m_row = (m_row == h - 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
   endtask

   // Append one frame to the stimulus list; kind selects the pixel pattern.
   task automatic add_frame(input int w, input int h, input int kind, input int stall_every,
                            input bit with_sof);
      int n;
      logic [7:0] p;
      n = 0;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            case (kind)
               0:       p = 8'(16 * r + c);
               1:       p = 8'(255 - (16 * r + c));
               2:       p = 8'(64 + 16 * r + c);
               default: p = 8'($urandom_range(0, 255));
            endcase
            st.push_back('{v: 1'b1, sof: (with_sof && r == 0 && c == 0), pix: p});
            n++;
            if (stall_every != 0 && n % stall_every == 0) begin
               repeat (3) st.push_back('{v: 1'b0, sof: 1'b1, pix: 8'hA5});
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got_s !== 42'h0 || s_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_small: valid=%b out=%h, required 0/0", s_out_valid, got_s);
      end
      checks++;
      if (got_l !== 42'h0 || l_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_large: valid=%b out=%h, required 0/0", l_out_valid, got_l);
      end
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      exp_t ex;
      int nwin = 0;
      st.delete();
      add_frame(4, 4, 0, 0, 1'b1);
      foreach (st[i]) begin
         drive(1'b0, st[i].v, st[i].sof, st[i].pix);
         @(posedge clk); #1;
         if (s_out_valid) begin
            checks++; nwin++;
            if (q.size() == 0) begin
               errors++; $display("FAIL basic_extra: out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               ex = q.pop_front();
               if (got_s !== ex.win || cyc != ex.cyc) begin
                  errors++;
                  $display("FAIL basic_win: got %h at cycle %0d, required %h at cycle %0d", got_s, cyc, ex.win, ex.cyc);
               end
            end
            if (nwin == 1) begin
               checks++;
               if (got_s !== {40'h01_10_11_12_21, 2'b00}) begin
                  errors++; $display("FAIL basic_first: got %h, required %h", got_s, {40'h01_10_11_12_21, 2'b00});
               end
            end
            if (nwin == 4) begin
               checks++;
               if (got_s !== {40'h12_21_22_23_32, 2'b11}) begin
                  errors++; $display("FAIL basic_last: got %h, required %h", got_s, {40'h12_21_22_23_32, 2'b11});
               end
            end
         end else begin
            checks++;
            if ({s_out_last, s_frame_done} !== 2'b00) begin
               errors++; $display("FAIL basic_idle: last/done=%b at cycle %0d, required 00", {s_out_last, s_frame_done}, cyc);
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      checks++;
      if (nwin != 4 || q.size() != 0 || s_out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_count: windows=%0d pending=%0d, required 4/0", nwin, q.size());
      end
   endtask

   task automatic test_stall();
      exp_t ex;
      int nwin = 0;
      logic [39:0] held = 40'h0;
      st.delete();
      add_frame(4, 4, 0, 2, 1'b1);
      foreach (st[i]) begin
         drive(1'b0, st[i].v, st[i].sof, st[i].pix);
         @(posedge clk); #1;
         if (s_out_valid) begin
            checks++; nwin++;
            if (q.size() == 0) begin
               errors++; $display("FAIL stall_extra: out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               ex = q.pop_front();
               if (got_s !== ex.win || cyc != ex.cyc) begin
                  errors++;
                  $display("FAIL stall_win: got %h at cycle %0d, required %h at cycle %0d", got_s, cyc, ex.win, ex.cyc);
               end
            end
            held = got_s[41:2];
         end else if (nwin > 0) begin
            checks++;
            if (got_s[41:2] !== held) begin
               errors++; $display("FAIL stall_hold: data %h, required held %h", got_s[41:2], held);
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      checks++;
      if (nwin != 4 || q.size() != 0) begin
         errors++; $display("FAIL stall_count: windows=%0d pending=%0d, required 4/0", nwin, q.size());
      end
   endtask

   task automatic test_back_to_back();
      exp_t ex;
      int nwin = 0;
      st.delete();
      add_frame(4, 4, 0, 0, 1'b1);
      add_frame(4, 4, 1, 0, 1'b1);
      foreach (st[i]) begin
         drive(1'b0, st[i].v, st[i].sof, st[i].pix);
         @(posedge clk); #1;
         if (s_out_valid) begin
            checks++; nwin++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_extra: out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               ex = q.pop_front();
               if (got_s !== ex.win || cyc != ex.cyc) begin
                  errors++;
                  $display("FAIL b2b_win: got %h at cycle %0d, required %h at cycle %0d", got_s, cyc, ex.win, ex.cyc);
               end
            end
            if (nwin == 5) begin
               checks++;
               if (got_s !== {40'hFE_EF_EE_ED_DE, 2'b00}) begin
                  errors++; $display("FAIL b2b_frame2_first: got %h, required %h", got_s, {40'hFE_EF_EE_ED_DE, 2'b00});
               end
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      checks++;
      if (nwin != 8 || q.size() != 0) begin
         errors++; $display("FAIL b2b_count: windows=%0d pending=%0d, required 8/0", nwin, q.size());
      end
   endtask

   task automatic test_sof_resync();
      exp_t ex;
      int nwin = 0;
      st.delete();
      for (int k = 0; k < 5; k++) begin
         st.push_back('{v: 1'b1, sof: (k == 0), pix: 8'(16 * (k / 4) + (k % 4))});
      end
      add_frame(4, 4, 2, 0, 1'b1);
      foreach (st[i]) begin
         drive(1'b0, st[i].v, st[i].sof, st[i].pix);
         @(posedge clk); #1;
         if (s_out_valid) begin
            checks++; nwin++;
            if (q.size() == 0) begin
               errors++; $display("FAIL sof_extra: out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               ex = q.pop_front();
               if (got_s !== ex.win || cyc != ex.cyc) begin
                  errors++;
                  $display("FAIL sof_win: got %h at cycle %0d, required %h at cycle %0d", got_s, cyc, ex.win, ex.cyc);
               end
            end
            if (nwin == 1) begin
               checks++;
               if (got_s !== {40'h41_50_51_52_61, 2'b00}) begin
                  errors++; $display("FAIL sof_first: got %h, required %h", got_s, {40'h41_50_51_52_61, 2'b00});
               end
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      checks++;
      if (nwin != 4 || q.size() != 0) begin
         errors++; $display("FAIL sof_count: windows=%0d pending=%0d, required 4/0", nwin, q.size());
      end
   endtask

   task automatic test_reset_mid();
      exp_t ex;
      int nwin = 0;
      st.delete();
      add_frame(4, 4, 0, 0, 1'b1);
      while (st.size() > 11) void'(st.pop_back());
      foreach (st[i]) begin
         drive(1'b0, st[i].v, st[i].sof, st[i].pix);
         @(posedge clk); #1;
         if (s_out_valid) begin
            checks++; nwin++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rstmid_extra: out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               ex = q.pop_front();
               if (got_s !== ex.win) begin
                  errors++; $display("FAIL rstmid_pre: got %h, required %h", got_s, ex.win);
               end
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (got_s !== 42'h0 || s_out_valid !== 1'b0 || nwin != 1) begin
         errors++; $display("FAIL rstmid_clear: valid=%b out=%h windows=%0d, required 0/0/1", s_out_valid, got_s, nwin);
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      m_row = 0; m_col = 0;
      q.delete();
      @(posedge clk); #1;
      nwin = 0;
      st.delete();
      add_frame(4, 4, 0, 0, 1'b0);
      foreach (st[i]) begin
         drive(1'b0, st[i].v, st[i].sof, st[i].pix);
         @(posedge clk); #1;
         if (s_out_valid) begin
            checks++; nwin++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rstmid_extra2: out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               ex = q.pop_front();
               if (got_s !== ex.win || cyc != ex.cyc) begin
                  errors++;
                  $display("FAIL rstmid_win: got %h at cycle %0d, required %h at cycle %0d", got_s, cyc, ex.win, ex.cyc);
               end
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      checks++;
      if (nwin != 4 || q.size() != 0) begin
         errors++; $display("FAIL rstmid_count: windows=%0d pending=%0d, required 4/0", nwin, q.size());
      end
   endtask

   task automatic test_large();
      exp_t ex;
      int nwin = 0;
      int nlast = 0;
      st.delete();
      m_row = 0; m_col = 0;
      add_frame(256, 256, 3, 0, 1'b1);
      foreach (st[i]) begin
         drive(1'b1, st[i].v, st[i].sof, st[i].pix);
         @(posedge clk); #1;
         if (l_out_valid) begin
            checks++; nwin++;
            if (l_out_last) nlast++;
            if (q.size() == 0) begin
               errors++; $display("FAIL large_extra: out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               ex = q.pop_front();
               if (got_l !== ex.win || cyc != ex.cyc) begin
                  errors++;
                  $display("FAIL large_win: got %h at cycle %0d, required %h at cycle %0d", got_l, cyc, ex.win, ex.cyc);
               end
            end
         end
      end
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      checks++;
      if (nwin != 64516 || nlast != 1 || q.size() != 0) begin
         errors++; $display("FAIL large_count: windows=%0d lasts=%0d pending=%0d, required 64516/1/0", nwin, nlast, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_sof_resync();
      test_reset_mid();
      test_large();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
